// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 8-way mux.
// Grants are one-hot and registered, and each owner's tenure is capped at BURST_LEN cycles while others wait.
module mux8_rr_arbiter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t           state_r;
  logic [7:0]       gnt_r;
  logic [2:0]       sel_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       last_r;

  logic [7:0]       own_mask_s;
  logic             own_req_s;
  logic             others_s;
  logic [2:0]       win_s;
  logic [7:0]       win_gnt_s;

  // First set bit of cand scanning last+1, last+2, ... with wrap; the owner itself is checked last,
  // so other pending requesters always win over the current owner.
  function automatic logic [2:0] rr_pick(input logic [7:0] cand, input logic [2:0] last);
    logic [2:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx   = last + 3'(k);
      pick  = (!found && cand[idx]) ? idx : pick;
      found = found | cand[idx];
    end
    return pick;
  endfunction

  // Arbitration decode: owner status and next winner from the sampled request vector.
  always_comb begin
    own_mask_s = 8'd1 << last_r;
    own_req_s  = req[last_r];
    others_s   = ((req & ~own_mask_s) != 8'd0);
    win_s      = rr_pick(req, last_r);
    win_gnt_s  = 8'd1 << win_s;
  end

  // Grant FSM with registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      gnt_r   <= 8'd0;
      sel_r   <= 3'd0;
      busy_r  <= 1'b0;
      cnt_r   <= '0;
      last_r  <= 3'd7;
    end else begin
      case (state_r)
        IDLE: begin
          if (req != 8'd0) begin
            state_r <= GRANT;
            gnt_r   <= win_gnt_s;
            sel_r   <= win_s;
            busy_r  <= 1'b1;
            cnt_r   <= '0;
            last_r  <= win_s;
          end else begin
            gnt_r  <= 8'd0;
            busy_r <= 1'b0;
          end
        end
        GRANT: begin
          // An owner drop takes precedence over burst expiry; both re-arbitrate from owner+1.
          if (!own_req_s) begin
            if (others_s) begin
              gnt_r  <= win_gnt_s;
              sel_r  <= win_s;
              busy_r <= 1'b1;
              cnt_r  <= '0;
              last_r <= win_s;
            end else begin
              state_r <= IDLE;
              gnt_r   <= 8'd0;
              busy_r  <= 1'b0;
              cnt_r   <= '0;
            end
          end else if (cnt_r == CNT_LAST) begin
            if (others_s) begin
              gnt_r  <= win_gnt_s;
              sel_r  <= win_s;
              busy_r <= 1'b1;
              last_r <= win_s;
            end else begin
              busy_r <= 1'b1;
            end
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 8'd0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_r;
  assign sel  = sel_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table, async-reset sequence,
// and randomized traffic against a tenure-counting reference model.
module tb_mux8_rr_arbiter;

  localparam int BL = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  mux8_rr_arbiter #(.BURST_LEN(BL), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index plus number of cycles it has held the mux in this burst.
  bit m_busy;
  int m_owner;
  int m_sel;
  int m_held;
  int m_last;

  function automatic int search(input logic [7:0] r, input int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_sel = 0; m_held = 0; m_last = 7;
  endtask

  task automatic model_grant(input int w);
    m_busy = 1'b1; m_owner = w; m_sel = w; m_held = 1; m_last = w;
  endtask

  task automatic model_step(input logic [7:0] r);
    logic [7:0] others;
    if (!m_busy) begin
      if (r != 8'd0) model_grant(search(r, m_last));
    end else begin
      others = r & ~(8'd1 << m_owner);
      if (!r[m_owner]) begin
        if (others != 8'd0) model_grant(search(r, m_owner));
        else m_busy = 1'b0;
      end else if (m_held == BL) begin
        if (others != 8'd0) model_grant(search(r, m_owner));
        else m_held = 1;
      end else begin
        m_held = m_held + 1;
      end
    end
  endtask

  function automatic logic [7:0] model_gnt();
    return m_busy ? (8'd1 << m_owner) : 8'd0;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s, input logic b);
    vec_t v;
    v.req = r; v.gnt = g; v.sel = s; v.busy = b;
    vecs.push_back(v);
  endfunction

  logic [7:0] cur;

  initial begin
    // Full contention: each index owns the mux for exactly BL cycles, wrapping 7->0.
    for (int i = 0; i < 36; i++) add(8'hFF, 8'd1 << ((i / 4) % 8), 3'((i / 4) % 8), 1'b1);
    // Owner 0 drops, lone requester 3 keeps the mux across counter wraps.
    for (int i = 0; i < 20; i++) add(8'h08, 8'h08, 3'd3, 1'b1);
    // Two requesters alternate in 4-cycle bursts.
    for (int i = 0; i < 12; i++) begin
      if (i < 4 || i >= 8) add(8'h81, 8'h80, 3'd7, 1'b1);
      else add(8'h81, 8'h01, 3'd0, 1'b1);
    end
    // Owner 2 drops with 5 pending: no idle bubble; then go idle with sel held.
    add(8'h04, 8'h04, 3'd2, 1'b1);
    add(8'h24, 8'h04, 3'd2, 1'b1);
    add(8'h20, 8'h20, 3'd5, 1'b1);
    add(8'h00, 8'h00, 3'd5, 1'b0);
    add(8'h00, 8'h00, 3'd5, 1'b0);
    // Idle search starts after last owner 5 and wraps to 4.
    add(8'h10, 8'h10, 3'd4, 1'b1);
    add(8'h10, 8'h10, 3'd4, 1'b1);
    add(8'h10, 8'h10, 3'd4, 1'b1);

    reset = 1'b1;
    req   = 8'hFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_gnt", gnt, 8'h00);
    check("reset_sel", {5'd0, sel}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      tick(vecs[i].req);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_sel", i), {5'd0, sel}, {5'd0, vecs[i].sel});
      check($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
    end

    // Asynchronous reset mid-burst must clear outputs before the next edge.
    #2 reset = 1'b1;
    #1;
    check("async_gnt", gnt, 8'h00);
    check("async_sel", {5'd0, sel}, 8'h00);
    check("async_busy", {7'd0, busy}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    check("held_reset_gnt", gnt, 8'h00);
    reset = 1'b0;
    // Fresh burst for 4 after release, then rotation to 5.
    for (int i = 0; i < 8; i++) begin
      tick(8'h30);
      check($sformatf("post_reset%0d_gnt", i), gnt, (i < 4) ? 8'h10 : 8'h20);
      check($sformatf("post_reset%0d_sel", i), {5'd0, sel}, (i < 4) ? 8'd4 : 8'd5);
    end

    // Randomized traffic with occasional asynchronous reset pulses.
    cur = 8'h00;
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0: cur = 8'($urandom) & 8'($urandom) & 8'($urandom);
        1: cur = 8'($urandom);
        2: cur = cur;
        default: cur = 8'd1 << $urandom_range(0, 7);
      endcase
      tick(cur);
      check("rand_gnt", gnt, model_gnt());
      check("rand_sel", {5'd0, sel}, 8'(m_sel));
      check("rand_busy", {7'd0, busy}, {7'd0, m_busy});
      check("rand_busy_eq_gnt", {7'd0, busy}, {7'd0, (gnt != 8'd0)});
      check("rand_onehot0", {7'd0, $onehot0(gnt)}, 8'h01);
      if ($urandom_range(0, 63) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        check("rand_reset_gnt", gnt, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
